work_sender: RTL

Host-side end of the miner's UART job link. Latches one mining job (midstate, work data, nonce range) from a parallel valid/ready interface, serializes it as a 52-byte 8N1 frame on `tx_serial`, and decodes the 4-byte golden-nonce replies arriving on `rx_serial`. Used in test rigs and multi-board controllers that drive one or more miner boards.

---
 rtl/miner_pkg.sv | 20 ++
 rtl/uart_rx_byte.sv | 93 +++++++++
 rtl/work_sender.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/miner_pkg.sv
// Shared types and constants for the host-side miner UART job link.
package miner_pkg;

    localparam int unsigned FRAME_BYTES     = 52;
    localparam int unsigned NONCE_BYTES     = 4;
    localparam int unsigned RX_TIMEOUT_BITS = 20;
    localparam int unsigned JOB_BITS        = FRAME_BYTES * 8;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    // Field order matches the on-wire byte order, MSB byte first.
    typedef struct packed {
        logic [255:0] midstate;
        logic [95:0]  work_data;
        logic [31:0]  nonce_min;
        logic [31:0]  nonce_max;
    } job_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: synchronizer, start-bit glitch filter, mid-bit sampler,
// and single-cycle strobes on the stop-bit sample cycle.
module uart_rx_byte
    import miner_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid_c,
    output logic       o_stop_err_c,
    output logic       o_busy_c
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);

    rx_state_t         r_state;
    logic [1:0]        r_sync;
    logic              r_rx_prev;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit;
    logic [7:0]        r_shift;
    logic              w_rx;
    logic              w_fall;
    logic              w_stop_sample;

    assign w_rx          = r_sync[1];
    assign w_fall        = r_rx_prev && !w_rx;
    assign w_stop_sample = (r_state == R_STOP) && (r_baud == BAUD_LAST);

    assign o_data       = r_shift;
    assign o_valid_c    = w_stop_sample && w_rx;
    assign o_stop_err_c = w_stop_sample && !w_rx;
    assign o_busy_c     = (r_state != R_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
            r_state   <= R_IDLE;
            r_baud    <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
        end else begin
            r_sync    <= {r_sync[0], i_rx};
            r_rx_prev <= w_rx;
            case (r_state)
                R_IDLE: begin
                    r_baud <= '0;
                    if (w_fall) begin
                        r_state <= R_START;
                    end
                end
                // A line that is high again at half a bit was a glitch, not a start bit.
                R_START: begin
                    if (r_baud == BAUD_HALF) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= w_rx ? R_IDLE : R_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud  <= '0;
                        r_shift <= {w_rx, r_shift[7:1]};
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == 3'd7) begin
                            r_state <= R_STOP;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                R_STOP: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud  <= '0;
                        r_state <= R_IDLE;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/work_sender.sv
// Host end of the miner UART link: serializes one 52-byte job frame and
// assembles 4-byte golden-nonce replies from the miner.
module work_sender
    import miner_pkg::*;
#(
    parameter int unsigned baud_rate    = 9600,
    parameter int unsigned sys_clk_freq = 48000000
) (
    input  logic         comm_clk,
    input  logic         reset,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [255:0] midstate,
    input  logic [95:0]  work_data,
    input  logic [31:0]  nonce_min,
    input  logic [31:0]  nonce_max,
    output logic         tx_serial,
    output logic         tx_busy,
    input  logic         rx_serial,
    output logic [31:0]  golden_nonce,
    output logic         golden_valid,
    output logic         rx_frame_err
);

    localparam int unsigned CLKS_PER_BIT = sys_clk_freq / baud_rate;
    localparam int unsigned BAUD_W       = $clog2(CLKS_PER_BIT);
    localparam int unsigned BYTE_W       = $clog2(FRAME_BYTES);
    localparam int unsigned IDX_W        = $clog2(NONCE_BYTES);
    localparam int unsigned GAP_CYCLES   = RX_TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int unsigned GAP_W        = $clog2(GAP_CYCLES + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(FRAME_BYTES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NONCE_BYTES - 1);

    tx_state_t           r_state;
    logic [JOB_BITS-1:0] r_shift;
    logic [7:0]          r_tx_byte;
    logic [BAUD_W-1:0]   r_baud;
    logic [2:0]          r_bit;
    logic [BYTE_W-1:0]   r_byte;
    job_t                w_job;
    logic                w_accept;

    assign w_job     = '{midstate: midstate, work_data: work_data,
                         nonce_min: nonce_min, nonce_max: nonce_max};
    assign job_ready = (r_state == IDLE) && !reset;
    assign w_accept  = job_valid && job_ready;

    // TX serializer: the frame shifts out MSB byte first, each byte LSB first.
    always_ff @(posedge comm_clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_tx_byte <= '0;
            r_baud    <= '0;
            r_bit     <= '0;
            r_byte    <= '0;
            tx_serial <= 1'b1;
            tx_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift   <= w_job;
                        r_baud    <= '0;
                        r_byte    <= '0;
                        tx_serial <= 1'b0;
                        tx_busy   <= 1'b1;
                        r_state   <= START;
                    end
                end
                START: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud    <= '0;
                        r_bit     <= '0;
                        tx_serial <= r_shift[JOB_BITS-8];
                        r_tx_byte <= 8'(r_shift[JOB_BITS-1 -: 8] >> 1);
                        r_shift   <= r_shift << 8;
                        r_state   <= DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud <= '0;
                        r_bit  <= r_bit + 1'b1;
                        if (r_bit == 3'd7) begin
                            tx_serial <= 1'b1;
                            r_state   <= STOP;
                        end else begin
                            tx_serial <= r_tx_byte[0];
                            r_tx_byte <= r_tx_byte >> 1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                STOP: begin
                    if (r_baud == BAUD_LAST) begin
                        r_baud <= '0;
                        if (r_byte == BYTE_LAST) begin
                            r_byte  <= '0;
                            tx_busy <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_byte    <= r_byte + 1'b1;
                            tx_serial <= 1'b0;
                            r_state   <= START;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    logic [7:0]         w_rx_data;
    logic               w_rx_valid;
    logic               w_rx_err;
    logic               w_rx_busy;
    logic [23:0]        r_acc;
    logic [IDX_W-1:0]   r_idx;
    logic [GAP_W-1:0]   r_gap;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .i_clk       (comm_clk),
        .i_reset     (reset),
        .i_rx        (rx_serial),
        .o_data      (w_rx_data),
        .o_valid_c   (w_rx_valid),
        .o_stop_err_c(w_rx_err),
        .o_busy_c    (w_rx_busy)
    );

    // Nonce assembler: the first three bytes wait in r_acc, the fourth completes the word.
    always_ff @(posedge comm_clk) begin
        if (reset) begin
            r_acc        <= '0;
            r_idx        <= '0;
            r_gap        <= '0;
            golden_nonce <= '0;
            golden_valid <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            golden_valid <= 1'b0;
            rx_frame_err <= 1'b0;
            if (w_rx_err) begin
                rx_frame_err <= 1'b1;
                r_idx        <= '0;
                r_acc        <= '0;
                r_gap        <= '0;
            end else if (w_rx_valid) begin
                r_acc <= {r_acc[15:0], w_rx_data};
                r_gap <= '0;
                if (r_idx == IDX_LAST) begin
                    golden_nonce <= {r_acc, w_rx_data};
                    golden_valid <= 1'b1;
                    r_idx        <= '0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end else if ((r_idx != '0) && !w_rx_busy) begin
                // A stalled partial nonce is dropped silently once the line idles too long.
                if (r_gap == GAP_W'(GAP_CYCLES)) begin
                    r_idx <= '0;
                    r_gap <= '0;
                end else begin
                    r_gap <= r_gap + 1'b1;
                end
            end else begin
                r_gap <= '0;
            end
        end
    end

endmodule
